// File: rtl/brisc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : brisc_pkg
//  Description : Shared constants and state encoding for BRISC run control.
//  Revision    : 1.0  initial release
// ============================================================================
package brisc_pkg;

    localparam int PC_W_DEF            = 8;
    localparam int FLUSH_CYCLES_DEF    = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;

    typedef enum logic [2:0] {
        SEQ_WAIT_LOAD = 3'd0,
        SEQ_RUN       = 3'd1,
        SEQ_FLUSH     = 3'd2,
        SEQ_HALT      = 3'd3,
        SEQ_STEP      = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/pipeline_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_sequencer_if
//  Description : Board I/O and pipeline-enable bundle for the run sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface pipeline_sequencer_if #(
    parameter int PC_W = 8
);
    logic            load_done;
    logic            run_sw;
    logic            step_btn;
    logic            jump_en;
    logic            bp_en;
    logic [PC_W-1:0] bp_addr;
    logic [PC_W-1:0] pc;
    logic            pc_en;
    logic            stage_en;
    logic            flush;
    logic            halted;
    logic [2:0]      state_dbg;
    logic [15:0]     run_cycles;

    modport master (
        output load_done, run_sw, step_btn, jump_en, bp_en, bp_addr, pc,
        input  pc_en, stage_en, flush, halted, state_dbg, run_cycles
    );

    modport slave (
        input  load_done, run_sw, step_btn, jump_en, bp_en, bp_addr, pc,
        output pc_en, stage_en, flush, halted, state_dbg, run_cycles
    );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : 2-FF synchroniser, stable-count debounce, rising-edge pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_btn,
    output logic      o_pulse
);
    localparam int            C_CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(DEBOUNCE_CYCLES - 1);

    logic            r_meta;
    logic            r_sync;
    logic            r_level;
    logic            r_pulse;
    logic [C_CW-1:0] r_cnt;

    // Level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta  <= i_btn;
            r_sync  <= r_meta;
            r_pulse <= 1'b0;
            if (r_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync;
                r_pulse <= r_sync;
            end else begin
                r_cnt <= r_cnt + C_CW'(1);
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_sequencer
//  Description : Run/halt/step/breakpoint sequencer for the 3-stage BRISC pipe.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_sequencer
    import brisc_pkg::*;
#(
    parameter int FLUSH_CYCLES    = FLUSH_CYCLES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int PC_W            = PC_W_DEF
) (
    input  wire logic            CLK,
    input  wire logic            RST,
    pipeline_sequencer_if.slave  bus
);
    localparam logic [1:0] C_FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    seq_state_t      r_state;
    seq_state_t      w_state_nxt;
    logic [1:0]      r_flush_cnt;
    logic [1:0]      w_flush_cnt_nxt;
    logic            r_from_step;
    logic            w_from_step_nxt;
    logic            r_bp_pending;
    logic            w_bp_pending_nxt;
    logic            r_bp_skip;
    logic [PC_W-1:0] r_pc_prev;
    logic            r_run_meta;
    logic            r_run_s;
    logic            r_run_s_d;
    logic [15:0]     r_run_cycles;
    logic            w_step_p;
    logic            w_bp_hit;
    logic            w_run_rise;
    logic            w_pc_en;
    logic            w_stage_en;
    logic            w_flush;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk     (CLK),
        .rst     (RST),
        .i_btn   (bus.step_btn),
        .o_pulse (w_step_p)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_run_meta <= 1'b0;
            r_run_s    <= 1'b0;
            r_run_s_d  <= 1'b0;
        end else begin
            r_run_meta <= bus.run_sw;
            r_run_s    <= r_run_meta;
            r_run_s_d  <= r_run_s;
        end
    end

    assign w_run_rise = r_run_s & ~r_run_s_d;
    assign w_bp_hit   = bus.bp_en & (bus.pc == bus.bp_addr) & ~r_bp_skip;

    always_comb begin
        w_state_nxt      = r_state;
        w_flush_cnt_nxt  = r_flush_cnt;
        w_from_step_nxt  = r_from_step;
        w_bp_pending_nxt = r_bp_pending;
        w_pc_en          = 1'b0;
        w_stage_en       = 1'b0;
        w_flush          = 1'b0;
        case (r_state)
            SEQ_WAIT_LOAD: begin
                if (bus.load_done) begin
                    w_state_nxt = r_run_s ? SEQ_RUN : SEQ_HALT;
                end
            end
            SEQ_RUN: begin
                w_stage_en = 1'b1;
                w_pc_en    = ~w_bp_hit;
                if (bus.jump_en) begin
                    w_state_nxt     = SEQ_FLUSH;
                    w_flush_cnt_nxt = C_FLUSH_LOAD;
                    w_from_step_nxt = 1'b0;
                end else if (w_bp_hit || !r_run_s) begin
                    w_state_nxt = SEQ_HALT;
                end
            end
            SEQ_FLUSH: begin
                w_stage_en = 1'b1;
                w_flush    = 1'b1;
                w_pc_en    = ~(w_bp_hit | r_bp_pending);
                if (w_bp_hit) begin
                    w_bp_pending_nxt = 1'b1;
                end
                if (r_flush_cnt == 2'd0) begin
                    // A hit in the final bubble still counts toward halting.
                    if (r_bp_pending || w_bp_hit || !r_run_s || r_from_step) begin
                        w_state_nxt = SEQ_HALT;
                    end else begin
                        w_state_nxt = SEQ_RUN;
                    end
                    w_bp_pending_nxt = 1'b0;
                    w_from_step_nxt  = 1'b0;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - 2'd1;
                end
            end
            SEQ_HALT: begin
                if (w_run_rise) begin
                    w_state_nxt = SEQ_RUN;
                end else if (w_step_p) begin
                    w_state_nxt = SEQ_STEP;
                end
            end
            SEQ_STEP: begin
                w_stage_en = 1'b1;
                w_pc_en    = 1'b1;
                if (bus.jump_en) begin
                    w_state_nxt     = SEQ_FLUSH;
                    w_flush_cnt_nxt = C_FLUSH_LOAD;
                    w_from_step_nxt = 1'b1;
                end else begin
                    w_state_nxt = SEQ_HALT;
                end
            end
            default: begin
                w_state_nxt = SEQ_WAIT_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= SEQ_WAIT_LOAD;
            r_flush_cnt  <= 2'd0;
            r_from_step  <= 1'b0;
            r_bp_pending <= 1'b0;
            r_bp_skip    <= 1'b0;
            r_pc_prev    <= '0;
            r_run_cycles <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_cnt  <= w_flush_cnt_nxt;
            r_from_step  <= w_from_step_nxt;
            r_bp_pending <= w_bp_pending_nxt;
            r_pc_prev    <= bus.pc;
            // Resuming from a breakpoint must not re-trigger on the same PC.
            if ((r_state == SEQ_HALT || r_state == SEQ_STEP) && (w_state_nxt != r_state)) begin
                r_bp_skip <= 1'b1;
            end else if (bus.pc != r_pc_prev) begin
                r_bp_skip <= 1'b0;
            end
            if (w_stage_en && !w_flush) begin
                r_run_cycles <= r_run_cycles + 16'd1;
            end
        end
    end

    assign bus.pc_en      = w_pc_en;
    assign bus.stage_en   = w_stage_en;
    assign bus.flush      = w_flush;
    assign bus.halted     = (r_state == SEQ_HALT);
    assign bus.state_dbg  = r_state;
    assign bus.run_cycles = r_run_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_sequencer
//  Description : Directed self-checking bench for pipeline_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] jmp_target;
    int         n_checks;
    int         n_errors;
    int         n_steps;
    logic       found;

    pipeline_sequencer_if #(.PC_W(8)) bus ();

    pipeline_sequencer #(
        .FLUSH_CYCLES    (2),
        .DEBOUNCE_CYCLES (4),
        .PC_W            (8)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock; the bench plays PC_control, loading on pc_en seen before the edge.
    task automatic cyc();
        logic en;
        logic jmp;
        #1;
        en  = bus.pc_en;
        jmp = bus.jump_en;
        @(posedge clk);
        #1;
        if (en) bus.pc = jmp ? jmp_target : bus.pc + 8'd1;
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        n_steps       = 0;
        found         = 1'b0;
        jmp_target    = 8'h00;
        rst           = 1'b1;
        bus.load_done = 1'b0;
        bus.run_sw    = 1'b1;
        bus.step_btn  = 1'b0;
        bus.jump_en   = 1'b0;
        bus.bp_en     = 1'b0;
        bus.bp_addr   = 8'h00;
        bus.pc        = 8'h00;

        repeat (3) cyc();
        chk_eq("rst_state", bus.state_dbg, 3'd0);
        chk_eq("rst_pc_en", bus.pc_en, 1'b0);
        chk_eq("rst_stage_en", bus.stage_en, 1'b0);
        chk_eq("rst_flush", bus.flush, 1'b0);
        chk_eq("rst_halted", bus.halted, 1'b0);
        chk_eq("rst_run_cycles", bus.run_cycles, 16'd0);

        rst = 1'b0;
        repeat (2) cyc();
        chk_eq("wait_load_state", bus.state_dbg, 3'd0);
        chk_eq("wait_load_stage_en", bus.stage_en, 1'b0);
        bus.load_done = 1'b1;
        cyc();
        chk_eq("run_state", bus.state_dbg, 3'd1);
        chk_eq("run_stage_en", bus.stage_en, 1'b1);
        chk_eq("run_pc_en", bus.pc_en, 1'b1);
        chk_eq("run_cycles_0", bus.run_cycles, 16'd0);
        cyc();
        chk_eq("run_cycles_1", bus.run_cycles, 16'd1);

        // Taken jump from RUN
        jmp_target  = 8'h05;
        bus.jump_en = 1'b1;
        chk_eq("jump_pc_en", bus.pc_en, 1'b1);
        cyc();
        bus.jump_en = 1'b0;
        chk_eq("flush1_state", bus.state_dbg, 3'd2);
        chk_eq("flush1_flush", bus.flush, 1'b1);
        chk_eq("flush1_stage_en", bus.stage_en, 1'b1);
        chk_eq("jump_pc_loaded", bus.pc, 8'h05);
        chk_eq("flush1_run_cycles", bus.run_cycles, 16'd2);
        cyc();
        chk_eq("flush2_flush", bus.flush, 1'b1);
        chk_eq("flush2_run_cycles", bus.run_cycles, 16'd2);
        cyc();
        chk_eq("post_flush_state", bus.state_dbg, 3'd1);
        chk_eq("post_flush_flush", bus.flush, 1'b0);
        chk_eq("post_flush_run_cycles", bus.run_cycles, 16'd2);
        chk_eq("post_flush_pc", bus.pc, 8'h07);

        // Breakpoint at 0x10
        bus.bp_addr = 8'h10;
        bus.bp_en   = 1'b1;
        found       = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (bus.pc == 8'h10) found = 1'b1;
        end
        chk_eq("bp_reached", found, 1'b1);
        chk_eq("bp_pc_en", bus.pc_en, 1'b0);
        chk_eq("bp_state_run", bus.state_dbg, 3'd1);
        cyc();
        chk_eq("bp_halt_state", bus.state_dbg, 3'd3);
        chk_eq("bp_halted", bus.halted, 1'b1);
        chk_eq("bp_pc_held", bus.pc, 8'h10);
        chk_eq("bp_run_cycles", bus.run_cycles, 16'd12);

        bus.run_sw = 1'b0;
        repeat (3) cyc();
        bus.run_sw = 1'b1;
        repeat (2) cyc();
        chk_eq("resume_wait_state", bus.state_dbg, 3'd3);
        cyc();
        chk_eq("resume_state", bus.state_dbg, 3'd1);
        chk_eq("resume_pc", bus.pc, 8'h10);
        chk_eq("resume_pc_en", bus.pc_en, 1'b1);
        cyc();
        chk_eq("resume_pc_11", bus.pc, 8'h11);
        chk_eq("resume_state_11", bus.state_dbg, 3'd1);
        cyc();
        chk_eq("resume_pc_12", bus.pc, 8'h12);

        // Switch-off halt
        bus.bp_en  = 1'b0;
        bus.run_sw = 1'b0;
        repeat (3) cyc();
        chk_eq("sw_halt_state", bus.state_dbg, 3'd3);
        chk_eq("sw_halt_pc", bus.pc, 8'h15);

        // Bouncy step button, then stable press
        for (int i = 0; i < 5; i++) begin
            bus.step_btn = 1'b1;
            cyc();
            if (bus.state_dbg == 3'd4) n_steps++;
            bus.step_btn = 1'b0;
            cyc();
            if (bus.state_dbg == 3'd4) n_steps++;
        end
        chk_eq("bounce_no_step", n_steps, 0);
        bus.step_btn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (bus.state_dbg == 3'd4) n_steps++;
        end
        chk_eq("step_count", n_steps, 1);
        chk_eq("step_pc", bus.pc, 8'h16);
        chk_eq("step_back_halt", bus.state_dbg, 3'd3);
        bus.step_btn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (bus.state_dbg == 3'd4) n_steps++;
        end
        chk_eq("release_no_step", n_steps, 1);
        chk_eq("release_pc", bus.pc, 8'h16);

        // Step onto a taken jump
        jmp_target   = 8'h40;
        bus.step_btn = 1'b1;
        found        = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cyc();
            if (bus.state_dbg == 3'd4) found = 1'b1;
        end
        chk_eq("step_jump_seen", found, 1'b1);
        bus.jump_en = 1'b1;
        chk_eq("step_jump_pc_en", bus.pc_en, 1'b1);
        chk_eq("step_jump_flush0", bus.flush, 1'b0);
        cyc();
        bus.jump_en = 1'b0;
        chk_eq("step_flush1_state", bus.state_dbg, 3'd2);
        chk_eq("step_jump_pc", bus.pc, 8'h40);
        cyc();
        chk_eq("step_flush2", bus.flush, 1'b1);
        cyc();
        chk_eq("step_flush_to_halt", bus.state_dbg, 3'd3);
        chk_eq("step_flush_done", bus.flush, 1'b0);

        // Reset in the middle of FLUSH
        bus.step_btn = 1'b0;
        repeat (8) cyc();
        bus.run_sw = 1'b1;
        repeat (3) cyc();
        chk_eq("rerun_state", bus.state_dbg, 3'd1);
        bus.jump_en = 1'b1;
        cyc();
        bus.jump_en = 1'b0;
        chk_eq("midflush_state", bus.state_dbg, 3'd2);
        rst = 1'b1;
        cyc();
        chk_eq("midrst_state", bus.state_dbg, 3'd0);
        chk_eq("midrst_pc_en", bus.pc_en, 1'b0);
        chk_eq("midrst_stage_en", bus.stage_en, 1'b0);
        chk_eq("midrst_flush", bus.flush, 1'b0);
        chk_eq("midrst_halted", bus.halted, 1'b0);
        chk_eq("midrst_run_cycles", bus.run_cycles, 16'd0);
        rst = 1'b0;
        cyc();
        chk_eq("post_rst_halt", bus.state_dbg, 3'd3);
        repeat (2) cyc();
        chk_eq("post_rst_run", bus.state_dbg, 3'd1);
        chk_eq("post_rst_stage_en", bus.stage_en, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
